// File: rtl/uart_axi_txn_sequencer.sv
// uart_axi_txn_sequencer: turns one parsed UART frame into N single-beat
// AXI4-Lite writes or reads (optional address auto-increment), then hands a
// status/count summary to the response builder and releases the frame.
// Optional watchdog: define UART_AXI_TXN_TIMEOUT_EN to abort a stalled beat
// after TIMEOUT_CYCLES cycles with status 0x03.
module uart_axi_txn_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_valid,
  input  logic [7:0]            frame_cmd,
  input  logic [ADDR_WIDTH-1:0] frame_addr,
  output logic                  frame_consumed,
  output logic [3:0]            data_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_we,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [7:0]            resp_status,
  output logic [4:0]            resp_count,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);
  localparam int STEP = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, W_ISSUE, W_RESP, R_ISSUE, R_DATA, RESP} state_t;
  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  fixed;
  logic [4:0]            len, len_req, count;
  logic [3:0]            idx, rd_tag;
  logic [7:0]            status;
  logic                  misaligned, w_iss_done, beat_ok, last, adv_w;
  logic                  timeout, to_go;

  // cmd[5:4] carry no meaning for this block
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^frame_cmd[5:4];

  assign misaligned = (frame_addr % ADDR_WIDTH'(STEP)) != '0;
  assign w_iss_done = (!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready);
  assign beat_ok    = (state == R_DATA) ? (axi_rresp == 2'b00) : (axi_bresp == 2'b00);
  assign last       = (count + 5'd1) == len;
  // Next write word is fetched during the B handshake so wdata loads on entry.
  assign adv_w      = (state == W_RESP) && axi_bvalid && beat_ok && !last;

  assign axi_awaddr  = addr;
  assign axi_araddr  = addr;
  assign resp_status = status;
  assign resp_count  = count;
  assign data_idx    = rd_we ? rd_tag : (adv_w ? idx + 4'd1 : idx);

  // requested length, clamped to MAX_WORDS
  always_comb begin
    len_req = {1'b0, frame_cmd[3:0]} + 5'd1;
    if (len_req > 5'(MAX_WORDS)) len_req = 5'(MAX_WORDS);
  end

`ifdef UART_AXI_TXN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          in_axi;
  assign in_axi  = (state == W_ISSUE) || (state == W_RESP) || (state == R_ISSUE) || (state == R_DATA);
  assign timeout = in_axi && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // watchdog: counts cycles spent in one AXI state, restarts on any state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          tcnt <= '0;
    else if (!in_axi || state_d != state) tcnt <= '0;
    else                                 tcnt <= tcnt + 1'b1;
  end
`else
  // watchdog not built: never fires
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // next state; a stalled beat is aborted only when no progress happens
  always_comb begin
    state_d = state;
    to_go   = 1'b0;
    case (state)
      IDLE:    if (frame_valid) state_d = misaligned ? RESP : (frame_cmd[7] ? R_ISSUE : W_ISSUE);
      W_ISSUE: if (w_iss_done)  state_d = W_RESP;
      W_RESP:  if (axi_bvalid)  state_d = (beat_ok && !last) ? W_ISSUE : RESP;
      R_ISSUE: if (axi_arready) state_d = R_DATA;
      R_DATA:  if (axi_rvalid)  state_d = (beat_ok && !last) ? R_ISSUE : RESP;
      RESP:    if (resp_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout && state_d == state) begin
      state_d = RESP;
      to_go   = 1'b1;
    end
  end

  // datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0; fixed <= 1'b0; len <= '0; count <= '0; idx <= '0; rd_tag <= '0;
      status <= '0; busy <= 1'b0; resp_valid <= 1'b0; frame_consumed <= 1'b0;
      rd_we <= 1'b0; rd_data <= '0; axi_wdata <= '0;
      axi_awvalid <= 1'b0; axi_wvalid <= 1'b0; axi_bready <= 1'b0;
      axi_arvalid <= 1'b0; axi_rready <= 1'b0;
    end else begin
      rd_we          <= 1'b0;
      frame_consumed <= 1'b0;
      if (to_go) begin
        axi_awvalid <= 1'b0; axi_wvalid <= 1'b0; axi_bready <= 1'b0;
        axi_arvalid <= 1'b0; axi_rready <= 1'b0;
        status      <= 8'h03;
        resp_valid  <= 1'b1;
      end else begin
        case (state)
          IDLE: if (frame_valid) begin
            fixed  <= frame_cmd[6];
            addr   <= frame_addr;
            len    <= len_req;
            idx    <= '0;
            count  <= '0;
            status <= 8'h00;
            busy   <= 1'b1;
            if (misaligned) begin
              status     <= 8'h02;
              resp_valid <= 1'b1;
            end else if (frame_cmd[7]) begin
              axi_arvalid <= 1'b1;
            end else begin
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              axi_wdata   <= wr_data;
            end
          end
          W_ISSUE: begin
            if (axi_awready) axi_awvalid <= 1'b0;
            if (axi_wready)  axi_wvalid  <= 1'b0;
            if (w_iss_done)  axi_bready  <= 1'b1;
          end
          W_RESP: if (axi_bvalid) begin
            axi_bready <= 1'b0;
            if (!beat_ok) begin
              status     <= 8'h01;
              resp_valid <= 1'b1;
            end else begin
              count <= count + 5'd1;
              if (last) resp_valid <= 1'b1;
              else begin
                idx         <= idx + 4'd1;
                addr        <= fixed ? addr : addr + ADDR_WIDTH'(STEP);
                axi_awvalid <= 1'b1;
                axi_wvalid  <= 1'b1;
                axi_wdata   <= wr_data;
              end
            end
          end
          R_ISSUE: if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
          end
          R_DATA: if (axi_rvalid) begin
            axi_rready <= 1'b0;
            if (!beat_ok) begin
              status     <= 8'h01;
              resp_valid <= 1'b1;
            end else begin
              rd_we   <= 1'b1;
              rd_data <= axi_rdata;
              rd_tag  <= idx;
              count   <= count + 5'd1;
              if (last) resp_valid <= 1'b1;
              else begin
                idx         <= idx + 4'd1;
                addr        <= fixed ? addr : addr + ADDR_WIDTH'(STEP);
                axi_arvalid <= 1'b1;
              end
            end
          end
          RESP: if (resp_ready) begin
            resp_valid     <= 1'b0;
            busy           <= 1'b0;
            frame_consumed <= 1'b1;
            idx            <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_axi_txn_sequencer.sv
// Directed bench for uart_axi_txn_sequencer with a small AXI4-Lite slave
// and a combinational parser write-data model.
module tb_uart_axi_txn_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_valid, resp_ready;
  logic [7:0]  frame_cmd;
  logic [31:0] frame_addr;
  logic        frame_consumed, rd_we, resp_valid, busy;
  logic [3:0]  data_idx;
  logic [31:0] wr_data, rd_data;
  logic [7:0]  resp_status;
  logic [4:0]  resp_count;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bready;
  logic        axi_arvalid, axi_arready, axi_rready;
  logic [1:0]  axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic        axi_bvalid = 1'b0, axi_rvalid = 1'b0;
  logic [31:0] axi_rdata = '0;

  // slave controls, written only by the test sequence
  logic        aw_stuck = 1'b0, b_hold = 1'b0;
  int          b_err_at = -1, r_base = 0;
  logic [31:0] r_vals [8];
  logic [31:0] wr_words [16];
  // slave logs, written only by the slave
  logic [31:0] aw_q[$], w_q[$], ar_q[$], rd_q[$];
  logic [3:0]  rt_q[$];
  int          b_n = 0, r_n = 0, any_valid_n = 0;

  int n_chk = 0, n_pass = 0;

  logic [153:0] zero_outs;
  assign zero_outs = {frame_consumed, rd_we, resp_valid, busy, axi_awvalid, axi_wvalid,
                      axi_bready, axi_arvalid, axi_rready, data_idx, resp_status, resp_count,
                      rd_data, axi_awaddr, axi_wdata, axi_araddr};

  assign wr_data     = wr_words[data_idx];
  assign axi_awready = !aw_stuck;
  assign axi_wready  = 1'b1;
  assign axi_arready = 1'b1;

  always #5 clk = ~clk;

  uart_axi_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
    .frame_addr(frame_addr), .frame_consumed(frame_consumed), .data_idx(data_idx),
    .wr_data(wr_data), .rd_data(rd_data), .rd_we(rd_we), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_status(resp_status), .resp_count(resp_count), .busy(busy),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  // AXI slave + monitor, acting on the falling edge away from the DUT edge
  always @(negedge clk) begin
    if (axi_awvalid && axi_awready) aw_q.push_back(axi_awaddr);
    if (axi_wvalid && axi_wready)   w_q.push_back(axi_wdata);
    if (axi_arvalid && axi_arready) ar_q.push_back(axi_araddr);
    if (axi_awvalid || axi_wvalid || axi_arvalid) any_valid_n++;
    if (rd_we) begin rt_q.push_back(data_idx); rd_q.push_back(rd_data); end
    if (axi_bvalid) axi_bvalid = 1'b0;
    else if (axi_bready && !b_hold) begin
      axi_bvalid = 1'b1;
      axi_bresp  = (b_n == b_err_at) ? 2'b10 : 2'b00;
      b_n++;
    end
    if (axi_rvalid) axi_rvalid = 1'b0;
    else if (axi_rready) begin
      axi_rvalid = 1'b1;
      axi_rresp  = 2'b00;
      axi_rdata  = r_vals[(r_n - r_base) & 7];
      r_n++;
    end
  end

  // present a frame, wait (bounded) for the summary, accept it, count consumed pulses
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input int limit,
                           output logic [7:0] st, output logic [4:0] cnt, output int fc, output bit tmo);
    @(negedge clk);
    frame_cmd = cmd; frame_addr = a; frame_valid = 1'b1;
    tmo = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (resp_valid) begin tmo = 1'b0; break; end
    end
    st = resp_status; cnt = resp_count; fc = 0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; frame_valid = 1'b0;
    if (frame_consumed) fc++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_consumed) fc++;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (zero_outs !== '0) $display("FAIL reset_outputs: got %h want 0", zero_outs); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write2;
    logic [7:0] st; logic [4:0] cnt; int fc; bit tmo; int ab, wb;
    ab = aw_q.size(); wb = w_q.size();
    wr_words[0] = 32'hA5A5_0001; wr_words[1] = 32'hB5B5_0002;
    run_frame(8'h01, 32'h1000, 200, st, cnt, fc, tmo);
    n_chk++; if (tmo) $display("FAIL wr2_timeout: no resp_valid within bound"); else n_pass++;
    n_chk++; if ({st, cnt} !== {8'h00, 5'd2}) $display("FAIL wr2_resp: got %h/%0d want 00/2", st, cnt); else n_pass++;
    n_chk++; if (aw_q.size() - ab != 2 || aw_q[ab] !== 32'h1000 || aw_q[ab+1] !== 32'h1004)
      $display("FAIL wr2_awaddr: got n=%0d %h %h want 2 00001000 00001004", aw_q.size() - ab, aw_q[ab], aw_q[ab+1]);
    else n_pass++;
    n_chk++; if (w_q.size() - wb != 2 || w_q[wb] !== 32'hA5A5_0001 || w_q[wb+1] !== 32'hB5B5_0002)
      $display("FAIL wr2_wdata: got n=%0d %h %h want 2 a5a50001 b5b50002", w_q.size() - wb, w_q[wb], w_q[wb+1]);
    else n_pass++;
    n_chk++; if (fc != 1) $display("FAIL wr2_consumed: got %0d pulses want 1", fc); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL wr2_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_read3;
    logic [7:0] st; logic [4:0] cnt; int fc; bit tmo; int ab, rb;
    ab = ar_q.size(); rb = rd_q.size();
    r_base = r_n; r_vals[0] = 32'h11; r_vals[1] = 32'h22; r_vals[2] = 32'h33;
    run_frame(8'h82, 32'h2000, 200, st, cnt, fc, tmo);
    n_chk++; if (tmo || {st, cnt} !== {8'h00, 5'd3}) $display("FAIL rd3_resp: got %h/%0d tmo=%0d want 00/3", st, cnt, tmo); else n_pass++;
    n_chk++; if (ar_q.size() - ab != 3 || ar_q[ab] !== 32'h2000 || ar_q[ab+1] !== 32'h2004 || ar_q[ab+2] !== 32'h2008)
      $display("FAIL rd3_araddr: got n=%0d %h %h %h want 3 2000 2004 2008", ar_q.size() - ab, ar_q[ab], ar_q[ab+1], ar_q[ab+2]);
    else n_pass++;
    n_chk++; if (rd_q.size() - rb != 3 || rd_q[rb] !== 32'h11 || rd_q[rb+1] !== 32'h22 || rd_q[rb+2] !== 32'h33)
      $display("FAIL rd3_data: got n=%0d %h %h %h want 3 11 22 33", rd_q.size() - rb, rd_q[rb], rd_q[rb+1], rd_q[rb+2]);
    else n_pass++;
    n_chk++; if (rt_q[rb] !== 4'd0 || rt_q[rb+1] !== 4'd1 || rt_q[rb+2] !== 4'd2)
      $display("FAIL rd3_idx: got %0d %0d %0d want 0 1 2", rt_q[rb], rt_q[rb+1], rt_q[rb+2]);
    else n_pass++;
    n_chk++; if (fc != 1) $display("FAIL rd3_consumed: got %0d pulses want 1", fc); else n_pass++;
  endtask

  task automatic test_fixed_read;
    logic [7:0] st; logic [4:0] cnt; int fc; bit tmo; int ab; bit same;
    ab = ar_q.size(); r_base = r_n;
    run_frame(8'hC3, 32'h30, 200, st, cnt, fc, tmo);
    n_chk++; if (tmo || {st, cnt} !== {8'h00, 5'd4}) $display("FAIL fixed_resp: got %h/%0d want 00/4", st, cnt); else n_pass++;
    same = 1'b1;
    for (int i = 0; i < 4; i++) if (ar_q[ab+i] !== 32'h30) same = 1'b0;
    n_chk++; if (ar_q.size() - ab != 4 || !same)
      $display("FAIL fixed_araddr: got n=%0d same=%0d want 4 all 00000030", ar_q.size() - ab, same);
    else n_pass++;
  endtask

  task automatic test_write_err;
    logic [7:0] st; logic [4:0] cnt; int fc; bit tmo; int ab;
    ab = aw_q.size(); b_err_at = b_n + 1;
    run_frame(8'h02, 32'h3000, 200, st, cnt, fc, tmo);
    b_err_at = -1;
    n_chk++; if (tmo || {st, cnt} !== {8'h01, 5'd1}) $display("FAIL wrerr_resp: got %h/%0d want 01/1", st, cnt); else n_pass++;
    n_chk++; if (aw_q.size() - ab != 2) $display("FAIL wrerr_aw_count: got %0d want 2", aw_q.size() - ab); else n_pass++;
  endtask

  task automatic test_misaligned;
    logic [7:0] st; logic [4:0] cnt; int fc; bit tmo; int vb;
    vb = any_valid_n;
    run_frame(8'h01, 32'h1002, 200, st, cnt, fc, tmo);
    n_chk++; if (tmo || {st, cnt} !== {8'h02, 5'd0}) $display("FAIL misalign_resp: got %h/%0d want 02/0", st, cnt); else n_pass++;
    n_chk++; if (any_valid_n != vb) $display("FAIL misalign_traffic: got %0d valid cycles want 0", any_valid_n - vb); else n_pass++;
    n_chk++; if (fc != 1) $display("FAIL misalign_consumed: got %0d pulses want 1", fc); else n_pass++;
  endtask

  task automatic test_wrap;
    logic [7:0] st; logic [4:0] cnt; int fc; bit tmo; int ab;
    ab = aw_q.size();
    run_frame(8'h01, 32'hFFFF_FFFC, 200, st, cnt, fc, tmo);
    n_chk++; if (tmo || {st, cnt} !== {8'h00, 5'd2}) $display("FAIL wrap_resp: got %h/%0d want 00/2", st, cnt); else n_pass++;
    n_chk++; if (aw_q[ab] !== 32'hFFFF_FFFC || aw_q[ab+1] !== 32'h0)
      $display("FAIL wrap_awaddr: got %h %h want fffffffc 00000000", aw_q[ab], aw_q[ab+1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit hit;
    b_hold = 1'b1;
    @(negedge clk);
    frame_cmd = 8'h01; frame_addr = 32'h4000; frame_valid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_bready) begin hit = 1'b1; break; end
    end
    n_chk++; if (!hit) $display("FAIL rstmid_reach: got no bready want W_RESP"); else n_pass++;
    #2 rst_n = 1'b0; frame_valid = 1'b0;
    #1;
    n_chk++; if (zero_outs !== '0) $display("FAIL rstmid_outputs: got %h want 0", zero_outs); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; b_hold = 1'b0;
    @(negedge clk);
  endtask

`ifdef UART_AXI_TXN_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] st; logic [4:0] cnt; int fc; bit tmo;
    aw_stuck = 1'b1;
    run_frame(8'h00, 32'h100, 1100, st, cnt, fc, tmo);
    aw_stuck = 1'b0;
    n_chk++; if (tmo || {st, cnt} !== {8'h03, 5'd0}) $display("FAIL timeout_resp: got %h/%0d tmo=%0d want 03/0", st, cnt, tmo); else n_pass++;
    n_chk++; if (axi_awvalid !== 1'b0) $display("FAIL timeout_awvalid: got %b want 0", axi_awvalid); else n_pass++;
  endtask
`endif

  initial begin
    frame_valid = 1'b0; frame_cmd = '0; frame_addr = '0; resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr_words[i] = 32'h0;
    for (int i = 0; i < 8; i++) r_vals[i] = 32'h0;
    test_reset;
    test_write2;
    test_read3;
    test_fixed_read;
    test_write_err;
    test_misaligned;
    test_wrap;
    test_reset_mid;
`ifdef UART_AXI_TXN_TIMEOUT_EN
    test_timeout;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
